// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves: word offsets,
// the bus acknowledge FSM encoding and the overflow counter width.
package opb_sw_reg_pkg;

    localparam logic OFF_DATA   = 1'b0;
    localparam logic OFF_STATUS = 1'b1;

    localparam int OVF_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP
    } ack_state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode, three-state acknowledge FSM and offset latch.
//
// Handshake: a transfer starts when the FSM is IDLE and a hit is present
// (select high and address inside [BASEADDR, HIGHADDR]). The next cycle is
// ACK, where ack is high for exactly one cycle, and it is followed by a
// single GAP cycle in which select is ignored, so a master that keeps select
// high for one cycle too long cannot be acked twice. The word offset and the
// read/write direction are captured only in IDLE, so they stay stable through
// ACK even if the master changes the bus.
module opb_slave_ack_fsm
    import opb_sw_reg_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01106300,
    parameter logic [AWIDTH-1:0] HIGHADDR = 32'h011063FF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:AWIDTH-1] abus,
    input  logic            select,
    input  logic            rnw,
    output logic            ack,
    output logic            off_q,
    output logic            rnw_q,
    output ack_state_t      state_dbg
);

    ack_state_t state;
    ack_state_t state_next;
    logic       hit;

    assign hit       = select && (abus >= BASEADDR) && (abus <= HIGHADDR);
    assign ack       = (state == S_ACK);
    assign state_dbg = state;

    // State register; reset drops any pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for a hit, ACK and GAP each last one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (hit) state_next = S_ACK;
            S_ACK:   state_next = S_GAP;
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Latch word offset (address bit 29 in MSB-0 numbering) and direction on
    // the accepting cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= OFF_DATA;
            rnw_q <= 1'b1;
        end else if (state == S_IDLE && hit) begin
            off_q <= abus[AWIDTH-3];
            rnw_q <= rnw;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Read-only software register: fabric writes a 32-bit value with a strobe,
// the PowerPC reads DATA (offset 0x0) and STATUS (offset 0x4) over OPB.
// STATUS holds a sticky VALID flag (bit 0, MSB) and, when the macro
// SIMULINK2PPC_OVFCNT_EN is defined, a saturating count of captures that
// overwrote an unread value in bits [16:31]. Writing 0x4 with DBus[31] and
// BE[3] set clears that count; all other writes are acked and ignored.
module opb_register_simulink2ppc
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01106300,
    parameter logic [31:0] C_HIGHADDR   = 32'h011063FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_we
);

    logic             ack;
    logic             off_q;
    logic             rnw_q;
    ack_state_t       fsm_state;
    logic             data_rd_ack;
    logic [31:0]      data_q;
    logic             valid_q;
    logic [OVF_W-1:0] ovf_cnt;
    logic [31:0]      rd_word;
    logic             unused_ok;

    opb_slave_ack_fsm #(
        .AWIDTH   (C_OPB_AWIDTH),
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk       (OPB_Clk),
        .rst       (OPB_Rst),
        .abus      (OPB_ABus),
        .select    (OPB_select),
        .rnw       (OPB_RNW),
        .ack       (ack),
        .off_q     (off_q),
        .rnw_q     (rnw_q),
        .state_dbg (fsm_state)
    );

    assign data_rd_ack = ack && rnw_q && (off_q == OFF_DATA);

    // Capture register and VALID: a new capture wins over a same-cycle DATA
    // read, so VALID stays set for the freshly captured value.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (user_data_we) begin
                data_q <= user_data_in;
            end
            if (user_data_we) begin
                valid_q <= 1'b1;
            end else if (data_rd_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef SIMULINK2PPC_OVFCNT_EN
    logic ovf_clr;

    assign ovf_clr = ack && !rnw_q && (off_q == OFF_STATUS)
                     && OPB_DBus[C_OPB_DWIDTH-1] && OPB_BE[3];

    // Overflow counter: counts captures onto an unread value; a same-cycle
    // DATA read means the old value was consumed, so nothing is lost.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (user_data_we && valid_q && !data_rd_ack && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`else
    assign ovf_cnt = '0;
`endif

    // Read mux: drives data only during a read ack, zero otherwise.
    always_comb begin
        rd_word = '0;
        if (ack && rnw_q) begin
            case (off_q)
                OFF_DATA:   rd_word = data_q;
                OFF_STATUS: rd_word = {valid_q, {(31-OVF_W){1'b0}}, ovf_cnt};
                default:    rd_word = '0;
            endcase
        end
    end

    assign Sl_DBus    = rd_word;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Inputs that carry no function here (burst hint, unused lanes, FSM view).
    assign unused_ok = ^{OPB_seqAddr, OPB_BE, OPB_DBus, fsm_state};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench for opb_register_simulink2ppc. Expectations come from a
// small behavioural model (m_data/m_valid/m_ovf) updated as stimulus is driven;
// read results are pushed to exp_q at issue time and popped on the ack.
// Compile with SIMULINK2PPC_OVFCNT_EN defined or not; the model follows.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] A_DATA   = 32'h01106300;
    localparam logic [31:0] A_STATUS = 32'h01106304;
    localparam logic [31:0] A_MISS   = 32'h01106400;

    logic        clk;
    logic        rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_we;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    logic [31:0] m_data;
    logic        m_valid;
    logic [15:0] m_ovf;

    logic [31:0] d;
    logic [31:0] e;
    bit          ok;
    int          lat;

    opb_register_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_data_we (user_data_we)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] m_status();
`ifdef SIMULINK2PPC_OVFCNT_EN
        return {m_valid, 15'b0, m_ovf};
`else
        return {m_valid, 31'b0};
`endif
    endfunction

    function automatic void m_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = '0;
    endfunction

    // Driver: one fabric capture strobe, with the model updated alongside.
    task automatic strobe(input logic [31:0] v);
        @(negedge clk);
        user_data_we = 1'b1;
        user_data_in = v;
        @(negedge clk);
        user_data_we = 1'b0;
        if (m_valid && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        m_valid = 1'b1;
        m_data  = v;
    endtask

    // Driver: one OPB transfer; reports ack latency in cycles and read data.
    task automatic bus_xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rd, output bit acked,
                            output int latency);
        @(negedge clk);
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_DBus   = wd;
        OPB_BE     = be;
        OPB_select = 1'b1;
        acked      = 1'b0;
        latency    = 0;
        rd         = '0;
        for (int i = 1; i <= 4 && !acked; i++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                acked   = 1'b1;
                latency = i;
                rd      = Sl_DBus;
            end
        end
        OPB_select = 1'b0;
        OPB_RNW    = 1'b1;
        OPB_DBus   = '0;
        OPB_BE     = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (Sl_xferAck === 1'b0 && Sl_DBus === 32'h0 && Sl_errAck === 1'b0 &&
            Sl_retry === 1'b0 && Sl_toutSup === 1'b0) n_pass++;
        else $display("FAIL reset_outputs: got ack=%b dbus=%h err=%b retry=%b tout=%b want all 0",
                      Sl_xferAck, Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup);
        rst = 1'b0;
        m_reset();

        exp_q.push_back(m_data);
        bus_xfer(A_DATA, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && lat == 1) n_pass++;
        else $display("FAIL reset_ack_latency: got acked=%0b latency=%0d want acked=1 latency=1", ok, lat);
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL reset_data: got %h want %h", d, e);

        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h0) n_pass++;
        else $display("FAIL reset_status: got %h acked=%0b want %h", d, ok, e);
    endtask

    task automatic test_capture_read();
        strobe(32'hDEADBEEF);
        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h80000000) n_pass++;
        else $display("FAIL capture_status_valid: got %h want %h", d, e);

        exp_q.push_back(m_data);
        bus_xfer(A_DATA, 1'b1, '0, 4'hF, d, ok, lat);
        m_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL capture_data: got %h want %h", d, e);

        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h0) n_pass++;
        else $display("FAIL capture_status_cleared: got %h want %h", d, e);
    endtask

    task automatic test_overflow_clear();
        strobe(32'h1);
        strobe(32'h2);
        strobe(32'h3);
        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL ovf_status: got %h want %h", d, e);

        // BE[3] low: must not clear the counter.
        bus_xfer(A_STATUS, 1'b0, 32'h00000001, 4'b1110, d, ok, lat);
        n_checks++;
        if (ok && d === 32'h0) n_pass++;
        else $display("FAIL write_ack_no_be: got acked=%0b dbus=%h want acked=1 dbus=0", ok, d);
        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL ovf_kept_without_be3: got %h want %h", d, e);

        bus_xfer(A_STATUS, 1'b0, 32'h00000001, 4'b1111, d, ok, lat);
        m_ovf = '0;
        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h80000000) n_pass++;
        else $display("FAIL ovf_cleared: got %h want %h", d, e);

        exp_q.push_back(m_data);
        bus_xfer(A_DATA, 1'b1, '0, 4'hF, d, ok, lat);
        m_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h3) n_pass++;
        else $display("FAIL ovf_last_data: got %h want %h", d, e);
    endtask

    task automatic test_simultaneous();
        strobe(32'h44);
        exp_q.push_back(m_data);
        @(negedge clk);
        OPB_ABus   = A_DATA;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(negedge clk);
        ok           = Sl_xferAck;
        d            = Sl_DBus;
        user_data_we = 1'b1;
        user_data_in = 32'h55;
        OPB_select   = 1'b0;
        @(negedge clk);
        user_data_we = 1'b0;
        m_data  = 32'h55;
        m_valid = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL simul_old_data: got acked=%0b %h want %h", ok, d, e);

        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h80000000) n_pass++;
        else $display("FAIL simul_status: got %h want %h", d, e);

        exp_q.push_back(m_data);
        bus_xfer(A_DATA, 1'b1, '0, 4'hF, d, ok, lat);
        m_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL simul_new_data: got %h want %h", d, e);
    endtask

    task automatic test_back_to_back();
        int n_acks;
        int first;
        int second;
        bit dbus_idle_ok;
        strobe($urandom_range(1, 32'h7FFF_FFFF));
        n_acks = 0;
        first = -1;
        second = -1;
        dbus_idle_ok = 1'b1;
        exp_q.push_back(m_status());
        exp_q.push_back(m_status());
        @(negedge clk);
        OPB_ABus   = A_STATUS;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                n_acks++;
                if (first < 0) first = i; else second = i;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                n_checks++;
                if (Sl_DBus === e) n_pass++;
                else $display("FAIL b2b_data: got %h want %h", Sl_DBus, e);
            end else if (Sl_DBus !== 32'h0) begin
                dbus_idle_ok = 1'b0;
            end
        end
        OPB_select = 1'b0;
        exp_q.delete();
        n_checks++;
        if (n_acks == 2 && first == 1 && second - first == 3) n_pass++;
        else $display("FAIL b2b_acks: got count=%0d first=%0d second=%0d want 2,1,4",
                      n_acks, first, second);
        n_checks++;
        if (dbus_idle_ok) n_pass++;
        else $display("FAIL b2b_dbus_idle: got nonzero dbus without ack want 0");
    endtask

    task automatic test_miss();
        int n_acks;
        bit dbus_zero;
        n_acks = 0;
        dbus_zero = 1'b1;
        @(negedge clk);
        OPB_ABus   = A_MISS;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (Sl_xferAck) n_acks++;
            if (Sl_DBus !== 32'h0) dbus_zero = 1'b0;
        end
        OPB_select = 1'b0;
        n_checks++;
        if (n_acks == 0 && dbus_zero) n_pass++;
        else $display("FAIL miss: got acks=%0d dbus_zero=%0b want acks=0 dbus_zero=1", n_acks, dbus_zero);
    endtask

    task automatic test_reset_mid_ack();
        strobe(32'hA5A5_0001);
        strobe(32'hA5A5_0002);
        @(negedge clk);
        OPB_ABus   = A_DATA;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(negedge clk);
        n_checks++;
        if (Sl_xferAck === 1'b1) n_pass++;
        else $display("FAIL rst_mid_pre_ack: got %b want 1", Sl_xferAck);
        rst        = 1'b1;
        OPB_select = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Sl_xferAck === 1'b0 && Sl_DBus === 32'h0) n_pass++;
        else $display("FAIL rst_mid_ack_dropped: got ack=%b dbus=%h want 0 0", Sl_xferAck, Sl_DBus);
        rst = 1'b0;
        m_reset();

        exp_q.push_back(m_status());
        bus_xfer(A_STATUS, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e && e === 32'h0) n_pass++;
        else $display("FAIL rst_mid_status: got %h want %h", d, e);

        exp_q.push_back(m_data);
        bus_xfer(A_DATA, 1'b1, '0, 4'hF, d, ok, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (ok && d === e) n_pass++;
        else $display("FAIL rst_mid_data: got %h want %h", d, e);
    endtask

    // Test sequence and final report.
    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b1;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_data_we = 1'b0;
        m_reset();

        test_reset();
        test_capture_read();
        test_overflow_clear();
        test_simultaneous();
        test_back_to_back();
        test_miss();
        test_reset_mid_ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
